hack_data_memory: RTL



---
 rtl/hack_data_memory_if.sv | 42 ++++
 rtl/hack_data_memory.sv | 136 +++++++++++++
 2 files changed

// File: rtl/hack_data_memory_if.sv
`default_nettype none
// ============================================================================
//  Module      : hack_data_memory_if
//  Description : Bus bundle between the Hack CPU core (plus the keyboard
//                source and the display controller) and hack_data_memory.
//                master = core/environment side, slave = the memory stage.
//  Ports       : addressM/outM/writeM/inM   - core data-memory access
//                kbd_valid/kbd_code/kbd_ready - external key stream
//                scr_valid/scr_addr/scr_data/scr_ready - buffered screen writes
//                scr_overflow/scr_level   - FIFO status
//  Revision    : 1.0 - initial release
// ============================================================================
interface hack_data_memory_if #(
    parameter int SCR_FIFO_DEPTH = 4
) ();
    localparam int LVL_W = $clog2(SCR_FIFO_DEPTH) + 1;

    logic [14:0]      addressM;
    logic [15:0]      outM;
    logic             writeM;
    logic [15:0]      inM;
    logic             kbd_valid;
    logic [15:0]      kbd_code;
    logic             kbd_ready;
    logic             scr_valid;
    logic [12:0]      scr_addr;
    logic [15:0]      scr_data;
    logic             scr_ready;
    logic             scr_overflow;
    logic [LVL_W-1:0] scr_level;

    modport master (
        output addressM, outM, writeM, kbd_valid, kbd_code, scr_ready,
        input  inM, kbd_ready, scr_valid, scr_addr, scr_data, scr_overflow, scr_level
    );

    modport slave (
        input  addressM, outM, writeM, kbd_valid, kbd_code, scr_ready,
        output inM, kbd_ready, scr_valid, scr_addr, scr_data, scr_overflow, scr_level
    );
endinterface
`default_nettype wire

// File: rtl/hack_data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : hack_data_memory
//  Description : Hack data-memory stage. Decodes the core's M access into
//                data RAM (0x0000-0x3FFF), screen shadow RAM (0x4000-0x5FFF)
//                and the keyboard register (0x6000). Screen writes are also
//                queued in a FIFO toward the display controller because the
//                core cannot be stalled; a dropped write sets a sticky flag.
//  Ports       : clock, reset (synchronous, active-high)
//                bus - hack_data_memory_if.slave (see interface header)
//  Revision    : 1.0 - initial release
// ============================================================================
module hack_data_memory #(
    parameter int RAM_AW         = 14,
    parameter int SCR_AW         = 13,
    parameter int SCR_FIFO_DEPTH = 4   // must match the interface instance
) (
    input  wire logic          clock,
    input  wire logic          reset,
    hack_data_memory_if.slave  bus
);
    localparam int c_PTR_W = $clog2(SCR_FIFO_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam logic [c_LVL_W-1:0] c_FULL = c_LVL_W'(SCR_FIFO_DEPTH);

    // Storage. RAM and shadow are deliberately not reset.
    logic [15:0]        r_ram  [0:(1<<RAM_AW)-1];
    logic [15:0]        r_scr  [0:(1<<SCR_AW)-1];
    logic [28:0]        r_fifo [0:SCR_FIFO_DEPTH-1];   // {addr[12:0], data}
    logic [15:0]        r_kbd;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic               r_overflow;

    logic        w_is_ram;
    logic        w_is_scr;
    logic        w_is_kbd;
    logic        w_wr_en;
    logic        w_push_req;
    logic        w_pop;
    logic        w_push_ok;
    logic        w_full;
    logic [15:0] w_in_m;
    logic [28:0] w_head;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_is_ram = ~bus.addressM[14];
    assign w_is_scr = (bus.addressM[14:13] == 2'b10);
    assign w_is_kbd = (bus.addressM == 15'h6000);

    // A write coinciding with reset is ignored everywhere.
    assign w_wr_en    = bus.writeM & ~reset;
    assign w_push_req = w_wr_en & w_is_scr;

    // ------------------------------------------------------------------
    // FIFO handshake. A pop frees a slot in the same cycle, so a push
    // while full is still accepted when the head is leaving.
    // ------------------------------------------------------------------
    assign w_full    = (r_level == c_FULL);
    assign w_pop     = bus.scr_valid & bus.scr_ready;
    assign w_push_ok = w_push_req & (~w_full | w_pop);
    assign w_head    = r_fifo[r_rd_ptr];

    // ------------------------------------------------------------------
    // Combinational read path (old contents on a same-cycle write)
    // ------------------------------------------------------------------
    always_comb begin
        w_in_m = 16'h0000;
        if (w_is_ram) begin
            w_in_m = r_ram[bus.addressM[RAM_AW-1:0]];
        end else if (w_is_scr) begin
            w_in_m = r_scr[bus.addressM[SCR_AW-1:0]];
        end else if (w_is_kbd) begin
            w_in_m = r_kbd;
        end
    end

    // ------------------------------------------------------------------
    // Array writes (no reset on contents)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_wr_en && w_is_ram) begin
            r_ram[bus.addressM[RAM_AW-1:0]] <= bus.outM;
        end
        if (w_wr_en && w_is_scr) begin
            r_scr[bus.addressM[SCR_AW-1:0]] <= bus.outM;
        end
        if (w_push_ok) begin
            r_fifo[r_wr_ptr] <= {bus.addressM[12:0], bus.outM};
        end
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_kbd      <= 16'h0000;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            // kbd_ready is high whenever reset is low
            if (bus.kbd_valid) begin
                r_kbd <= bus.kbd_code;
            end
            // Pointers are power-of-two wide, so they wrap naturally.
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= r_level + c_LVL_W'(w_push_ok) - c_LVL_W'(w_pop);
            if (w_push_req && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.inM          = w_in_m;
    assign bus.kbd_ready    = ~reset;
    assign bus.scr_valid    = (r_level != '0);
    assign bus.scr_addr     = w_head[28:16];
    assign bus.scr_data     = w_head[15:0];
    assign bus.scr_overflow = r_overflow;
    assign bus.scr_level    = r_level;
endmodule
`default_nettype wire
